memory_wrapper: RTL and testbench

MEMORY_WRAPPER -- requirements
Module: memory_wrapper

---
 rtl/memory_wrapper_pkg.sv | 16 +
 rtl/memory_wrapper_sdp_ram.sv | 35 +++
 rtl/memory_wrapper.sv | 108 ++++++++++
 tb/tb_memory_wrapper.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_wrapper_pkg.sv
// Shared constants for the AXI-Stream FIFO wrapper and its storage.
package memory_wrapper_pkg;

    localparam int MW_MEM_SIZE    = 4096;
    localparam int MW_ADDR_WIDTH  = 12;
    localparam int MW_DATA_WIDTH  = 32;
    localparam int MW_STRB_WIDTH  = MW_DATA_WIDTH / 8;
    // One stored entry is {tlast, tstrb, tdata}.
    localparam int MW_ENTRY_WIDTH = MW_DATA_WIDTH + MW_STRB_WIDTH + 1;

    // Entry width for an arbitrary data width.
    function automatic int mw_entry_width(input int dw);
        return dw + dw / 8 + 1;
    endfunction

endpackage

// File: rtl/memory_wrapper_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
// The read register doubles as the wrapper's output data stage, so it holds
// its value when re is low and clears on reset.
module sdp_ram #(
    parameter int DEPTH  = 4096,
    parameter int AW     = 12,
    parameter int WIDTH  = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port: contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port: capture addressed word only when a load is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/memory_wrapper.sv
// AXI-Stream FIFO: MEM_SIZE entries of {tlast, tstrb, tdata}, with a
// registered output stage that streams at one beat per cycle.
// Occupancy counts every accepted entry not yet read out, including the one
// sitting in the output stage; rd_ptr points at the next entry to load.
module memory_wrapper
    import memory_wrapper_pkg::*;
#(
    parameter int MEM_SIZE   = MW_MEM_SIZE,
    parameter int ADDR_WIDTH = MW_ADDR_WIDTH,
    parameter int DATA_WIDTH = MW_DATA_WIDTH
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    input  logic                    m01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int EW = DATA_WIDTH + SW + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;
    logic                  vld_q, vld_d;

    logic                  wr_en;
    logic                  rd_done;
    logic                  load;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic [EW-1:0]         ram_rdata;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(MEM_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshakes and output-stage load decision.
    always_comb begin
        s01_axis_tready = (occ_q != (ADDR_WIDTH + 1)'(MEM_SIZE));
        wr_en           = s01_axis_tvalid & s01_axis_tready;
        rd_done         = vld_q & m01_axis_tready;
        // Entries still in RAM, i.e. not yet moved to the output stage.
        ram_cnt         = occ_q - {{ADDR_WIDTH{1'b0}}, vld_q};
        load            = (ram_cnt != '0) & (~vld_q | m01_axis_tready);
    end

    // Next-state for pointers, occupancy and output valid.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        vld_d    = vld_q;
        if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (load)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_en, rd_done})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        if (load)         vld_d = 1'b1;
        else if (rd_done) vld_d = 1'b0;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            vld_q    <= vld_d;
        end
    end

    // The RAM read register is the output data stage: loaded with the head
    // entry together with vld_q, held otherwise.
    sdp_ram #(
        .DEPTH (MEM_SIZE),
        .AW    (ADDR_WIDTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (axis_aclk),
        .rst   (axis_areset),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata}),
        .re    (load),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign m01_axis_tvalid = vld_q;
    assign m01_axis_tdata  = ram_rdata[DATA_WIDTH-1:0];
    assign m01_axis_tstrb  = ram_rdata[DATA_WIDTH +: SW];
    assign m01_axis_tlast  = ram_rdata[EW-1];

endmodule

// File: tb/tb_memory_wrapper.sv
// Scoreboard bench for memory_wrapper: writes push expected beats, a
// monitor pops and compares on every output handshake.
module tb_memory_wrapper;

    localparam int MS = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tvalid;
    logic        m_tlast;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_n = 0, hs_first = 0, hs_last = 0, max_occ = 0;
    logic [36:0] exp_q[$];

    memory_wrapper dut (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .s01_axis_tdata  (s_tdata),
        .s01_axis_tstrb  (s_tstrb),
        .s01_axis_tvalid (s_tvalid),
        .s01_axis_tlast  (s_tlast),
        .s01_axis_tready (s_tready),
        .m01_axis_tready (m_tready),
        .m01_axis_tdata  (m_tdata),
        .m01_axis_tstrb  (m_tstrb),
        .m01_axis_tvalid (m_tvalid),
        .m01_axis_tlast  (m_tlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Offer one beat and wait (bounded) until it is accepted.
    task automatic wr(input logic [31:0] d, input logic [3:0] s, input logic l, output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        s_tdata = d; s_tstrb = s; s_tlast = l; s_tvalid = 1'b1;
        while (!acc && waits < 20) begin
            @(negedge clk); acc = s_tready;
            @(posedge clk); #1;
            waits++;
        end
        if (acc) exp_q.push_back({l, s, d});
        else chk("wr_timeout", 64'(acc), 64'(1'b1));
    endtask

    task automatic idle_in();
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(posedge clk); n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        #1;
    endtask

    // Monitor: scoreboard compare on handshake, stability check on stall.
    initial begin
        logic [36:0] cur, prev, e;
        logic        prev_stall;
        int          oc;
        prev = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            cur = {m_tlast, m_tstrb, m_tdata};
            oc  = int'(dut.occ_q);
            if (oc > max_occ) max_occ = oc;
            if (!rst && prev_stall && m_tvalid) chk("hold_stable", 64'(cur), 64'(prev));
            if (!rst && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(cur), 64'h1_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'(cur), 64'(e));
                end
                if (hs_n == 0) hs_first = cyc;
                hs_last = cyc;
                hs_n++;
            end
            prev_stall = !rst && m_tvalid && !m_tready;
            prev = cur;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int w;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("tready_in_reset", 64'(s_tready), 64'd1);
        chk("tvalid_in_reset", 64'(m_tvalid), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tready", 64'(s_tready), 64'd1);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_outs", 64'({m_tlast, m_tstrb, m_tdata}), 64'd0);
        @(posedge clk); #1;

        // Three beats with the sink stalled: first beat presented and held.
        wr(32'h55, 4'h1, 1'b1, w);
        wr(32'h22, 4'h1, 1'b1, w);
        wr(32'h24, 4'h1, 1'b1, w);
        idle_in();
        repeat (3) begin
            @(negedge clk);
            chk("stall_tvalid", 64'(m_tvalid), 64'd1);
            chk("stall_tdata", 64'(m_tdata), 64'h55);
        end
        @(posedge clk); #1;

        // Release the sink: three beats on consecutive cycles, then empty.
        m_tready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("burst_tvalid", 64'(m_tvalid), 64'd1);
        end
        @(negedge clk);
        chk("burst_empty", 64'(m_tvalid), 64'd0);
        chk("burst_sb_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // Continuous streaming of 100 words with both sides ready.
        hs_n = 0; max_occ = 0;
        for (int i = 0; i < 100; i++) wr(32'hA000_0000 + i, 4'(i), i[0], w);
        idle_in();
        wait_drain(50);
        chk("stream_beats", 64'(hs_n), 64'd100);
        chk("stream_span", 64'(hs_last - hs_first), 64'd99);
        chk("stream_max_occ_le2", 64'(max_occ <= 2), 64'd1);

        // Fill to capacity with the sink stalled.
        m_tready = 1'b0;
        for (int i = 0; i < MS; i++) wr(32'h1000_0000 + i, 4'(i), i[1], w);
        s_tdata = 32'hDEAD_BEEF; s_tstrb = 4'hF; s_tlast = 1'b1; s_tvalid = 1'b1;
        @(negedge clk);
        chk("full_tready", 64'(s_tready), 64'd0);
        chk("full_occ", 64'(dut.occ_q), 64'(MS));
        @(posedge clk); #1;
        m_tready = 1'b1;
        @(negedge clk);
        chk("full_tready_during_read", 64'(s_tready), 64'd0);
        @(posedge clk); #1;
        m_tready = 1'b0;
        @(negedge clk);
        chk("freed_tready", 64'(s_tready), 64'd1);
        exp_q.push_back({1'b1, 4'hF, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("refull_tready", 64'(s_tready), 64'd0);
        @(posedge clk); #1;
        m_tready = 1'b1;
        wait_drain(MS + 50);
        @(negedge clk);
        chk("drained_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge clk); #1;

        // Reset with three words buffered.
        m_tready = 1'b0;
        wr(32'h0000_0011, 4'h3, 1'b0, w);
        wr(32'h0000_0012, 4'h5, 1'b0, w);
        wr(32'h0000_0013, 4'h7, 1'b1, w);
        idle_in();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("areset_tvalid", 64'(m_tvalid), 64'd0);
        chk("areset_outs", 64'({m_tlast, m_tstrb, m_tdata}), 64'd0);
        chk("areset_tready", 64'(s_tready), 64'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        m_tready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_reset_no_data", 64'(m_tvalid), 64'd0);
        end
        @(posedge clk); #1;
        wr(32'h0000_0077, 4'h9, 1'b1, w);
        idle_in();
        chk("post_reset_first_write_waits", 64'(w), 64'd1);
        wait_drain(10);
        chk("post_reset_beats", 64'(exp_q.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
